// File: rtl/prio_arb_fsm.sv
// Three-requester arbiter FSM with registered one-hot grant, bounded hold time and a one-cycle idle gap.
// Define PRIO_ARB_RR_EN for round-robin arbitration; fixed priority (req[0] highest) otherwise.
module prio_arb_fsm #(
  parameter int HOLD_MAX = 8,
  parameter int CW       = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] req,
  input  logic       done,
  output logic [2:0] gnt,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam logic [CW-1:0] CNT_LIM = CW'(HOLD_MAX - 1);
  localparam logic [CW-1:0] CNT_SAT = '1;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    win_q, win_d;
  logic [2:0]    gnt_q, gnt_d;
  logic          busy_q, busy_d;
  logic          timeout_q, timeout_d;
  logic [1:0]    start;
  logic [1:0]    sel;
  logic          win_req;

  // First set request found when scanning upward from index start, wrapping at 3.
  function automatic logic [1:0] pick(input logic [2:0] r, input logic [1:0] s);
    logic [1:0] p;
    p = 2'd0;
    case (s)
      2'd1:    p = r[1] ? 2'd1 : (r[2] ? 2'd2 : 2'd0);
      2'd2:    p = r[2] ? 2'd2 : (r[0] ? 2'd0 : 2'd1);
      default: p = r[0] ? 2'd0 : (r[1] ? 2'd1 : 2'd2);
    endcase
    return p;
  endfunction

  function automatic logic [2:0] onehot(input logic [1:0] i);
    logic [2:0] o;
    o = 3'b000;
    case (i)
      2'd0:    o = 3'b001;
      2'd1:    o = 3'b010;
      2'd2:    o = 3'b100;
      default: o = 3'b000;
    endcase
    return o;
  endfunction

`ifdef PRIO_ARB_RR_EN
  logic [1:0] last_q, last_d;

  assign start = (last_q == 2'd2) ? 2'd0 : last_q + 2'd1;

  always_comb begin
    last_d = last_q;
    if (state_q == IDLE && req != 3'b000) last_d = sel;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= 2'd2;
    else        last_q <= last_d;
  end
`else
  assign start = 2'd0;
`endif

  assign sel     = pick(req, start);
  assign win_req = |(req & onehot(win_q));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    win_d     = win_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (req != 3'b000) begin
          win_d   = sel;
          cnt_d   = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        // done and withdrawal take precedence over the hold limit, suppressing timeout
        if (done || !win_req) begin
          state_d = GAP;
        end else if (cnt_q == CNT_LIM) begin
          state_d   = GAP;
          timeout_d = 1'b1;
        end else if (cnt_q != CNT_SAT) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    gnt_d  = (state_d == GRANT) ? onehot(win_d) : 3'b000;
    busy_d = (state_d == GRANT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      win_q     <= 2'd0;
      gnt_q     <= 3'b000;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      win_q     <= win_d;
      gnt_q     <= gnt_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
    end
  end

  assign gnt     = gnt_q;
  assign busy    = busy_q;
  assign timeout = timeout_q;

endmodule

// File: doc/prio_arb_fsm.md
# prio_arb_fsm

Three-requester arbiter FSM for a shared single-port resource that sits in front of the resource's sequencing FSMs. It samples requests, issues a registered one-hot grant, and holds that grant until the winner signals `done`, drops its request, or exhausts a bounded hold time. It then inserts a one-cycle idle gap before re-arbitrating. Outputs are registered from next-state, so grants are glitch-free at the resource boundary.

## Interface
- `HOLD_MAX`, default 8: maximum consecutive cycles one grant may be held. Legal range 2..2^CW-1.
- `CW`, default 4: width of the hold counter.
- `clk` input 1: clock; all logic is on the rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `req` input [2:0]: per-requester request; level-sensitive, held high while service is wanted.
- `done` input 1: current grantee finished; sampled only in GRANT.
- `gnt` output reg [2:0]: one-hot grant, or zero; registered.
- `busy` output reg 1: high while in GRANT; registered.
- `timeout` output reg 1: one-cycle pulse when a grant is forcibly revoked; registered.

## Operation
- States: IDLE (2'd0), GRANT (2'd1), GAP (2'd2). Encoding 2'd3 is unreachable and recovers to IDLE.
- Reset values: state IDLE, `gnt`=3'b000, `busy`=0, `timeout`=0, hold counter `cnt`=0, winner register `win`=0, last-grantee register `last`=2.
- IDLE:
  - If `req`≠0, select the winner, load `win`, clear `cnt`, and go to GRANT.
  - Otherwise stay in IDLE.
- Fixed priority (default): `req[0]` beats `req[1]`, which beats `req[2]`.
- GRANT transitions, evaluated in this priority order:
  1. `done`=1 → GAP.
  2. `req[win]`=0 (requester withdrew) → GAP.
  3. `cnt`==HOLD_MAX-1 → GAP, with `timeout` pulsed.
  4. Otherwise stay in GRANT and increment `cnt`.
- `done` or withdrawal in the same cycle as the limit wins. `timeout` is not pulsed in that case.
- GAP: unconditionally go to IDLE. `gnt`=0 and `busy`=0 throughout. This guarantees at least one dead cycle between grantees.
- Output logic is driven from nextstate:
  - `gnt` = one-hot(`win`) when nextstate is GRANT, else 0.
  - `busy` = (nextstate == GRANT).
  - `timeout` = 1 only on the GRANT→GAP transition taken by the hold limit. It defaults to 0 every cycle.
- Requests that arrive during GRANT or GAP are not latched. They are re-sampled in IDLE.
- `cnt` saturates and never wraps; it is cleared on every IDLE→GRANT transition.

## Timing
- Grant latency: `req` high in IDLE at edge N → `gnt` and `busy` high after edge N.
- Maximum hold: `gnt` is high for exactly HOLD_MAX cycles when never released. `timeout` is high for the one cycle after `gnt` falls, coincident with GAP.
- Release: `done` sampled at edge M → `gnt` low after edge M.
- Back-to-back service: the next `gnt` rises after edge M+2 (GAP at M+1, IDLE arbitrates at M+2).
- Single-cycle `done` in the first GRANT cycle gives a 1-cycle grant.
- Async reset mid-grant: `gnt`, `busy` and `timeout` drop immediately, with no GAP. The first grant after reset release follows the normal IDLE latency.

## Configuration
- `PRIO_ARB_RR_EN` defined: round-robin arbitration.
  - The search starts at (`last`+1) mod 3 and wraps.
  - `last` is loaded with `win` on each IDLE→GRANT transition.
  - Because `last` resets to 2, the first winner is the lowest set index.
- Not defined: fixed priority as above. `last` is not implemented.
- Ports and timing are identical in both builds.

## Test plan
- Reset, then `req`=3'b101 → `gnt`=3'b001 one cycle later; `busy`=1; `timeout`=0.
- HOLD_MAX=4, `req[1]` held high, no `done` → `gnt`=3'b010 for exactly 4 cycles, then a 1-cycle `timeout` pulse during GAP, then `gnt`=3'b010 again 2 cycles after the fall.
- `done` and the hold limit in the same cycle → transition to GAP with `timeout`=0.
- `req`=3'b111 held, `done` pulsed after each grant:
  - Fixed build: grant sequence 001, 001, 001.
  - `PRIO_ARB_RR_EN` build: grant sequence 001, 010, 100, 001.
- Grantee drops `req[2]` mid-grant while `req[0]` rises → `gnt` falls the next cycle, GAP follows, then `gnt`=3'b001.
- `rst_n` asserted asynchronously while `gnt`=3'b100 → all outputs are 0 before the next clock edge; after release, `req`=3'b100 is granted with normal 1-cycle latency.
